hex_keypad_entry: RTL and testbench

//   Scans a 4x4 matrix hex keypad, debounces it and shifts each accepted key into a
//   16-bit, 4-hex-digit entry register. The register is read by the 4-digit 7-segment

---
 rtl/hex_keypad_entry.sv | 177 +++++++++++++++++
 tb/tb_hex_keypad_entry.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with frame-based debounce and a 4-digit shift-in entry register.
// Each accepted key produces one digit_valid pulse; holding a key never repeats it.
module hex_keypad_entry #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear,
    output logic [15:0] value,
    output logic        digit_valid,
    output logic [3:0]  key_code,
    output logic        key_held
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DB_LAST  = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, PRESSED} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

    state_t             state, state_n;
    logic [3:0]         row_p0, row_p1;
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         col_idx;
    logic               col_end, frame_end;
    res_t               acc_kind, merged_kind;
    logic [3:0]         acc_key, merged_key;
    logic [3:0]         row_low;
    logic               frame_single;
    logic [3:0]         cand, cnt, rel_cnt;

    function automatic logic [1:0] row_enc(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (r[i]) idx = 2'(i);
        return idx;
    endfunction

    // Row synchronizer: idle (all rows high) out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= row;
            row_p1 <= row_p0;
        end
    end

    // Column scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (col_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign col       = ~(4'b0001 << col_idx);
    assign col_end   = (div_cnt == DIV_LAST);
    assign frame_end = col_end && (col_idx == 2'd3);

    // Fold this column's sample into the frame result; a second low row anywhere makes it MULTI
    always_comb begin
        row_low     = ~row_p1;
        merged_kind = acc_kind;
        merged_key  = acc_key;
        if (row_low != 4'd0) begin
            if ($onehot(row_low) && (acc_kind == RES_NONE)) begin
                merged_kind = RES_SINGLE;
                merged_key  = {row_enc(row_low), col_idx};
            end else begin
                merged_kind = RES_MULTI;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_kind <= RES_NONE;
            acc_key  <= 4'd0;
        end else if (frame_end) begin
            acc_kind <= RES_NONE;
            acc_key  <= 4'd0;
        end else if (col_end) begin
            acc_kind <= merged_kind;
            acc_key  <= merged_key;
        end
    end

    assign frame_single = frame_end && (merged_kind == RES_SINGLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:
                if (frame_single)
                    state_n = (DEBOUNCE_SCANS == 1) ? ACCEPT : DEBOUNCE;
            DEBOUNCE:
                if (frame_end) begin
                    if (frame_single && (merged_key == cand)) begin
                        if (4'(cnt + 4'd1) == DB_LAST) state_n = ACCEPT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            ACCEPT:
                state_n = PRESSED;
            PRESSED:
                if (frame_end && !frame_single && (4'(rel_cnt + 4'd1) == DB_LAST))
                    state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    always_comb begin
        digit_valid = (state == ACCEPT);
        key_held    = (state == PRESSED);
    end

    // Press and release debounce counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand    <= 4'd0;
            cnt     <= 4'd0;
            rel_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE:
                    if (frame_single) begin
                        cand <= merged_key;
                        cnt  <= 4'd1;
                    end
                DEBOUNCE:
                    if (frame_single && (merged_key == cand))
                        cnt <= cnt + 4'd1;
                ACCEPT:
                    rel_cnt <= 4'd0;
                PRESSED:
                    if (frame_end)
                        rel_cnt <= frame_single ? 4'd0 : rel_cnt + 4'd1;
                default: ;
            endcase
        end
    end

    // clear wins over a coincident shift-in, but key_code still tracks the accepted key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= 16'd0;
            key_code <= 4'd0;
        end else begin
            if (clear)
                value <= 16'd0;
            else if (state == ACCEPT)
                value <= {value[11:0], cand};
            if (state == ACCEPT)
                key_code <= cand;
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Randomized and directed bench for hex_keypad_entry with a frame-level keypad model
// and a scoreboard checked whenever digit_valid pulses.
module tb_hex_keypad_entry;

    localparam int SD = 4;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] value;
    logic        digit_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] pressed = 16'h0;

    hex_keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clear(clear),
        .value(value), .digit_valid(digit_valid), .key_code(key_code), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            if (pressed[k] && !col[kk[1:0]]) row[kk[3:2]] = 1'b0;
        end
    end

    typedef struct {
        logic [3:0]  key;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [15:0] m_val;
    bit          m_held;
    int          m_run;
    int          m_rel;
    logic [3:0]  m_key;
    bit          m_pend;
    logic [3:0]  m_pend_key;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val  = 16'h0;
        m_held = 1'b0;
        m_run  = 0;
        m_rel  = 0;
        m_key  = 4'h0;
        m_pend = 1'b0;
    endtask

    // Frame-level rules: DS identical single-key frames accept a key; DS non-single frames release it
    task automatic model_frame(input logic [15:0] mask);
        int pc;
        int k;
        pc = $countones(mask);
        k = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        if (!m_held) begin
            if (pc == 1) begin
                if (m_run > 0 && 4'(k) != m_key) begin
                    m_run = 0;
                end else begin
                    if (m_run == 0) m_key = 4'(k);
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
            if (m_run == DS) begin
                m_pend     = 1'b1;
                m_pend_key = m_key;
                m_held     = 1'b1;
                m_rel      = 0;
                m_run      = 0;
            end
        end else begin
            if (pc == 1) m_rel = 0;
            else         m_rel++;
            if (m_rel == DS) begin
                m_held = 1'b0;
                m_rel  = 0;
            end
        end
    endtask

    // One 16-cycle frame starting at column 0; clr0 drives clear in its first cycle
    task automatic run_frame(input logic [15:0] mask, input bit clr0);
        if (m_pend) begin
            m_val = {m_val[11:0], m_pend_key};
            if (clr0) m_val = 16'h0;
            sb.push_back('{m_pend_key, m_val});
            m_pend = 1'b0;
        end
        if (clr0) m_val = 16'h0;
        pressed = mask;
        clear   = clr0;
        @(negedge clk);
        clear = 1'b0;
        repeat (SD * 4 - 1) @(negedge clk);
        model_frame(mask);
        check("frame_col", 16'(col), 16'hE);
        check("frame_key_held", 16'(key_held), 16'(m_held && !m_pend));
        check("frame_value", value, m_val);
    endtask

    task automatic frames(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) run_frame(mask, 1'b0);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && digit_valid === 1'b1) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_digit: got key_code %0h with no digit expected at %0t", key_code, $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_key_code", 16'(key_code), 16'(e.key));
                    check("sb_value", value, e.val);
                    check("sb_pulse_width", 16'(digit_valid), 16'h0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mask;
        int          kind, len, ka, kb;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_col", 16'(col), 16'hE);
        check("rst_value", value, 16'h0);
        check("rst_digit_valid", 16'(digit_valid), 16'h0);
        check("rst_key_code", 16'(key_code), 16'h0);
        check("rst_key_held", 16'(key_held), 16'h0);
        rst_n = 1'b1;

        // Idle scan sequence over two frames
        for (int i = 1; i <= SD * 8; i++) begin
            logic [3:0] exp_col;
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / SD) % 4));
            check("scan_col", 16'(col), 16'(exp_col));
        end
        model_frame(16'h0);
        model_frame(16'h0);

        // Key 6 held six frames, then released
        frames(16'h0040, 6);
        check("k6_value", value, 16'h0006);
        check("k6_key_code", 16'(key_code), 16'h6);
        check("k6_key_held", 16'(key_held), 16'h1);
        frames(16'h0000, 4);

        // Keys 1..5
        for (int k = 1; k <= 5; k++) begin
            frames(16'(1 << k), 4);
            frames(16'h0000, 4);
        end
        check("seq_value", value, 16'h2345);
        check("seq_key_code", 16'(key_code), 16'h5);

        // Key 9 bouncing never reaches three consecutive frames
        frames(16'h0200, 2);
        frames(16'h0000, 1);
        frames(16'h0200, 2);
        frames(16'h0000, 3);
        check("bounce_value", value, 16'h2345);

        // Keys 0 and F together
        frames(16'h8001, 5);
        frames(16'h0000, 2);
        check("multi_value", value, 16'h2345);

        // Build 1234, then clear coincident with accepting A
        run_frame(16'h0000, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            frames(16'(1 << k), 3);
            frames(16'h0000, 3);
        end
        check("pre_clear_value", value, 16'h1234);
        frames(16'h0400, 3);
        run_frame(16'h0400, 1'b1);
        check("clr_acc_value", value, 16'h0);
        check("clr_acc_key_code", 16'(key_code), 16'hA);
        frames(16'h0000, 3);

        // Rebuild a nonzero value, then reset during debounce of key 7
        frames(16'h0002, 3);
        frames(16'h0000, 3);
        frames(16'h0080, 2);
        pressed = 16'h0080;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_col", 16'(col), 16'hE);
        check("arst_value", value, 16'h0);
        check("arst_digit_valid", 16'(digit_valid), 16'h0);
        check("arst_key_held", 16'(key_held), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        frames(16'h0080, 2);
        check("post_rst_no_digit", value, 16'h0);
        frames(16'h0080, 1);
        frames(16'h0000, 3);
        check("post_rst_value", value, 16'h0007);

        // Randomized key activity
        for (int seg = 0; seg < 60; seg++) begin
            kind = $urandom_range(0, 99);
            len  = $urandom_range(1, 5);
            ka   = $urandom_range(0, 15);
            kb   = (ka + $urandom_range(1, 15)) % 16;
            if (kind < 40)      mask = 16'h0;
            else if (kind < 85) mask = 16'(1 << ka);
            else                mask = 16'(1 << ka) | 16'(1 << kb);
            for (int f = 0; f < len; f++)
                run_frame(mask, $urandom_range(0, 15) == 0);
        end
        frames(16'h0000, 4);
        repeat (2) @(negedge clk);
        check("sb_drained", 16'(sb.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
